dcache_controller: RTL
======================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 32 lines x 256 bits, direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed below.
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- MemRead_i  in  1  pipeline load request
- MemWrite_i  in  1  pipeline store request
- Addr_i  in  32  byte address: tag=[31:10], index=[9:5], word=[4:2]
- WriteData_i  in  32  store data
- ReadData_o  out  32  load data; valid when CacheStall_o=0
- CacheStall_o  out  1  freeze pipeline registers
- mem_req_o  out  1  memory transaction request
- mem_we_o  out  1  1=line write-back, 0=line fill
- mem_addr_o  out  32  line-aligned address, bits [4:0]=0
- mem_wdata_o  out  256  write-back line
- mem_rdata_i  in  256  fill line
- mem_ack_i  in  1  one-cycle transaction completion

Function
REQ-003 Internal per-line state SHALL be valid, dirty, tag[21:0] and data[255:0].
REQ-004 hit = (MemRead_i|MemWrite_i) & valid[index] & (tag[index]==Addr_i[31:10]); the equality SHALL be combinational.
REQ-005 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE and UPDATE.
REQ-006 In IDLE with no request: CacheStall_o=0 and mem_req_o=0.
REQ-007 In IDLE on hit: CacheStall_o=0 in the same cycle, and ReadData_o SHALL be data[index] word [Addr_i[4:2]] combinationally (zero latency).
REQ-008 A store hit SHALL write WriteData_i into the selected word and set dirty=1 at the next rising edge.
REQ-009 When MemRead_i and MemWrite_i are both 1, the access SHALL be treated as a store; ReadData_o SHALL show the pre-store word.
REQ-010 In IDLE on miss: CacheStall_o=1 in the same cycle; next state SHALL be WRITEBACK if valid&dirty, else ALLOCATE.
REQ-011 In WRITEBACK the outputs SHALL be: mem_req_o=1, mem_we_o=1, mem_addr_o={tag[index],index,5'b0}, mem_wdata_o=data[index]; the FSM SHALL hold until mem_ack_i, then go to ALLOCATE.
REQ-012 In ALLOCATE the outputs SHALL be: mem_req_o=1, mem_we_o=0, mem_addr_o={Addr_i[31:5],5'b0}; on mem_ack_i the block SHALL latch mem_rdata_i into data[index], set valid=1, dirty=0 and tag=Addr_i[31:10], then go to UPDATE.
REQ-013 UPDATE SHALL last exactly one cycle with CacheStall_o=1, then return to IDLE, where the access re-evaluates as a hit.
REQ-014 CacheStall_o SHALL be 1 in every non-IDLE state.
REQ-015 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be stable from request until ack.
REQ-016 mem_ack_i SHALL be ignored when mem_req_o=0.
REQ-017 Miss penalty SHALL be 1 + ack latency + 1 cycles for a clean miss; a dirty miss SHALL add the write-back ack latency.
REQ-018 Addr_i, MemRead_i, MemWrite_i and WriteData_i SHALL be held stable by the pipeline while CacheStall_o=1; the block SHALL NOT latch them.
REQ-019 In non-IDLE states mem_addr_o and mem_wdata_o SHALL be 0 when not specified above.

Reset
REQ-020 On rising edge with rst_i=1: state=IDLE and all valid and dirty bits cleared; tag and data SHALL NOT be cleared.
REQ-021 While in reset and on the cycle after: CacheStall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0 and ReadData_o don't-care (no hit possible).
REQ-022 Reset asserted in WRITEBACK or ALLOCATE SHALL abandon the transaction: mem_req_o=0 from the cycle after the edge, and a late mem_ack_i SHALL be ignored.
REQ-023 rst_i SHALL take priority over any simultaneous mem_ack_i or store hit.

Verification
REQ-024 The bench SHALL check: after reset, load 0x0000_0040 -> CacheStall_o=1; ALLOCATE with mem_addr_o=0x0000_0040 and mem_we_o=0; ack after 3 cycles -> UPDATE -> IDLE; ReadData_o = fill word 0; 5 stall cycles total.
REQ-025 The bench SHALL check: store 0xDEADBEEF to 0x0000_0044 after the fill -> no stall, dirty[2]=1; load 0x0000_0044 -> 0xDEADBEEF with zero latency.
REQ-026 The bench SHALL check: load 0x0000_0440 (same index 2, new tag) -> WRITEBACK with mem_addr_o=0x0000_0040 and mem_wdata_o word 1 = 0xDEADBEEF, then ALLOCATE to 0x0000_0440.
REQ-027 The bench SHALL check: mem_ack_i pulsed in IDLE -> no state change and no array update.
REQ-028 The bench SHALL check: rst_i asserted during ALLOCATE, then ack arrives next cycle -> state IDLE, mem_req_o=0, valid[index]=0, and a retried load misses.
REQ-029 The bench SHALL check: MemRead_i=MemWrite_i=1 on a hit -> ReadData_o shows the old word and the store commits at the edge.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller: 32 lines x 256 bits.
// Hits complete combinationally; misses stall the pipeline through write-back/allocate/update.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         MemRead_i,
  input  logic         MemWrite_i,
  input  logic [31:0]  Addr_i,
  input  logic [31:0]  WriteData_i,
  output logic [31:0]  ReadData_o,
  output logic         CacheStall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;

  state_e       state_q, state_d;
  logic [31:0]  valid_q, valid_d;
  logic [31:0]  dirty_q, dirty_d;
  logic [21:0]  tag_q [32];
  logic [255:0] data_q [32];

  logic [21:0]  tag_d;
  logic         tag_we;
  logic [255:0] data_d;
  logic         data_we;

  logic [4:0]   index;
  logic [2:0]   word;
  logic [255:0] cur_line;
  logic         req_any;
  logic         hit;
  logic         unused_addr_lsb;

  assign index           = Addr_i[9:5];
  assign word            = Addr_i[4:2];
  assign cur_line        = data_q[index];
  assign req_any         = MemRead_i | MemWrite_i;
  assign hit             = req_any & valid_q[index] & (tag_q[index] == Addr_i[31:10]);
  assign ReadData_o      = cur_line[{word, 5'b0} +: 32];
  assign unused_addr_lsb = ^Addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = Addr_i[31:10];
    tag_we       = 1'b0;
    data_d       = cur_line;
    data_we      = 1'b0;
    CacheStall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (hit) begin
            if (MemWrite_i) begin
              data_d[{word, 5'b0} +: 32] = WriteData_i;
              data_we                    = 1'b1;
              dirty_d[index]             = 1'b1;
            end
          end else begin
            CacheStall_o = 1'b1;
            state_d      = (valid_q[index] & dirty_q[index]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        CacheStall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = {tag_q[index], index, 5'b0};
        mem_wdata_o  = cur_line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        CacheStall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_addr_o   = {Addr_i[31:5], 5'b0};
        if (mem_ack_i) begin
          data_d         = mem_rdata_i;
          data_we        = 1'b1;
          tag_we         = 1'b1;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          state_d        = UPDATE;
        end
      end
      UPDATE: begin
        CacheStall_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any transaction immediately, so the bus is quiet during the reset cycle.
    if (rst_i) begin
      CacheStall_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are never cleared, but reset still blocks a coincident write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (data_we) data_q[index] <= data_d;
      if (tag_we)  tag_q[index]  <= tag_d;
    end
  end

endmodule
